// File: rtl/simple_ahb_if.sv
// AHB-Lite bus bundle around the simple_ahb decoder/default-slave block.
//   m_* : upstream master side (request in, response out of the block)
//   s_* : downstream slave side (request out of the block, response in)
// Modports:
//   master : view of the upstream AHB master
//   slave  : view of the downstream AHB slave
//   bridge : view of simple_ahb itself, sitting between the two
interface simple_ahb_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  // Master side
  logic [ADDR_W-1:0] m_haddr;
  logic [1:0]        m_htrans;
  logic              m_hwrite;
  logic [2:0]        m_hsize;
  logic [DATA_W-1:0] m_hwdata;
  logic [DATA_W-1:0] m_hrdata;
  logic              m_hready;
  logic              m_hresp;

  // Slave side
  logic              s_hsel;
  logic [ADDR_W-1:0] s_haddr;
  logic [1:0]        s_htrans;
  logic              s_hwrite;
  logic [2:0]        s_hsize;
  logic [DATA_W-1:0] s_hwdata;
  logic              s_hreadyin;
  logic [DATA_W-1:0] s_hrdata;
  logic              s_hreadyout;
  logic              s_hresp;

  modport master (
    output m_haddr, m_htrans, m_hwrite, m_hsize, m_hwdata,
    input  m_hrdata, m_hready, m_hresp
  );

  modport slave (
    input  s_hsel, s_haddr, s_htrans, s_hwrite, s_hsize, s_hwdata, s_hreadyin,
    output s_hrdata, s_hreadyout, s_hresp
  );

  modport bridge (
    input  m_haddr, m_htrans, m_hwrite, m_hsize, m_hwdata,
    output m_hrdata, m_hready, m_hresp,
    output s_hsel, s_haddr, s_htrans, s_hwrite, s_hsize, s_hwdata, s_hreadyin,
    input  s_hrdata, s_hreadyout, s_hresp
  );

endinterface

// File: rtl/simple_ahb.sv
// Single-slave AHB-Lite decoder with a built-in default slave.
// Addresses inside the SLV_BASE/SLV_MASK window are routed to the downstream
// slave; NONSEQ/SEQ transfers outside it get the two-cycle ERROR response,
// IDLE/BUSY outside it get a zero-wait OKAY.
// Ports:
//   hclk      : bus clock, rising edge
//   hresetN   : synchronous active-low reset
//   bus       : simple_ahb_if.bridge (master-side and slave-side AHB signals)
//   err_count : saturating count of completed ERROR responses
module simple_ahb #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] SLV_BASE = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] SLV_MASK = 32'hFFFF_0000
) (
  input  logic                hclk,
  input  logic                hresetN,
  simple_ahb_if.bridge        bus,
  output logic [7:0]          err_count
);

  // Data-phase owner
  localparam logic [1:0] OwnNone  = 2'd0;
  localparam logic [1:0] OwnSlave = 2'd1;
  localparam logic [1:0] OwnDflt  = 2'd2;

  // Default-slave error FSM
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StErr1 = 2'd1;
  localparam logic [1:0] StErr2 = 2'd2;

  logic [1:0] owner_q, owner_d;
  logic [1:0] state_q, state_d;
  logic [7:0] err_count_q, err_count_d;
  logic       hit;
  logic       dflt_cap;

  assign hit = ((bus.m_haddr & SLV_MASK) == SLV_BASE);

  // Request side is purely combinational; the master holds it across waits.
  assign bus.s_hsel     = hit;
  assign bus.s_haddr    = bus.m_haddr;
  assign bus.s_htrans   = bus.m_htrans;
  assign bus.s_hwrite   = bus.m_hwrite;
  assign bus.s_hsize    = bus.m_hsize;
  assign bus.s_hwdata   = bus.m_hwdata;
  assign bus.s_hreadyin = bus.m_hready;

  // Response mux, selected by whoever owns the current data phase.
  always_comb begin
    bus.m_hready = 1'b1;
    bus.m_hresp  = 1'b0;
    bus.m_hrdata = {DATA_W{1'b0}};
    case (owner_q)
      OwnSlave: begin
        bus.m_hready = bus.s_hreadyout;
        bus.m_hresp  = bus.s_hresp;
        bus.m_hrdata = bus.s_hrdata;
      end
      OwnDflt: begin
        bus.m_hready = (state_q != StErr1);
        bus.m_hresp  = (state_q != StIdle);
      end
      default: ;
    endcase
  end

  // An unmapped active transfer accepted on this edge.
  assign dflt_cap = bus.m_hready & ~hit & bus.m_htrans[1];

  always_comb begin
    owner_d = owner_q;
    if (bus.m_hready) begin
      if (hit) begin
        owner_d = OwnSlave;
      end else if (bus.m_htrans[1]) begin
        owner_d = OwnDflt;
      end else begin
        owner_d = OwnNone;
      end
    end
  end

  always_comb begin
    state_d = StIdle;
    case (state_q)
      StIdle:  state_d = dflt_cap ? StErr1 : StIdle;
      StErr1:  state_d = StErr2;
      StErr2:  state_d = dflt_cap ? StErr1 : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    err_count_d = err_count_q;
    if (bus.m_hready && bus.m_hresp && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetN) begin
      owner_q     <= OwnNone;
      state_q     <= StIdle;
      err_count_q <= 8'd0;
    end else begin
      owner_q     <= owner_d;
      state_q     <= state_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;

endmodule

// File: tb/tb_simple_ahb.sv
// Self-checking bench for simple_ahb: directed scenarios followed by random
// traffic, all compared against a transfer-level reference model.
module tb_simple_ahb;

  logic       hclk = 1'b0;
  logic       hresetN;
  logic [7:0] err_count;

  always #5 hclk = ~hclk;

  simple_ahb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  simple_ahb #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .SLV_BASE(32'h0000_0000),
    .SLV_MASK(32'hFFFF_0000)
  ) dut (
    .hclk     (hclk),
    .hresetN  (hresetN),
    .bus      (bus),
    .err_count(err_count)
  );

  int n_vec = 0;
  int n_mis = 0;

  // Reference model: what kind of data phase is in flight.
  // kind 0 = no transfer, 1 = slave transfer, 2 = error response
  int          kind      = 0;
  int          err_phase = 0;  // 1 = first error cycle, 2 = second
  int          cnt       = 0;
  logic        exp_ready;
  logic        exp_resp;
  logic [31:0] exp_rdata;
  logic        exp_hit;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Evaluate the model and compare all outputs mid-cycle.
  task automatic sample();
    @(negedge hclk);
    exp_hit = (bus.m_haddr < 32'h0001_0000);
    case (kind)
      1: begin
        exp_ready = bus.s_hreadyout;
        exp_resp  = bus.s_hresp;
        exp_rdata = bus.s_hrdata;
      end
      2: begin
        exp_ready = (err_phase == 2);
        exp_resp  = 1'b1;
        exp_rdata = 32'h0;
      end
      default: begin
        exp_ready = 1'b1;
        exp_resp  = 1'b0;
        exp_rdata = 32'h0;
      end
    endcase
    check("m_hready",   {31'h0, bus.m_hready},   {31'h0, exp_ready});
    check("m_hresp",    {31'h0, bus.m_hresp},    {31'h0, exp_resp});
    check("m_hrdata",   bus.m_hrdata,            exp_rdata);
    check("s_hreadyin", {31'h0, bus.s_hreadyin}, {31'h0, exp_ready});
    check("s_hsel",     {31'h0, bus.s_hsel},     {31'h0, exp_hit});
    check("s_haddr",    bus.s_haddr,             bus.m_haddr);
    check("s_ctrl",     {26'h0, bus.s_htrans, bus.s_hwrite, bus.s_hsize},
                        {26'h0, bus.m_htrans, bus.m_hwrite, bus.m_hsize});
    check("s_hwdata",   bus.s_hwdata,            bus.m_hwdata);
    check("err_count",  {24'h0, err_count},      cnt);
  endtask

  // Advance the model across the rising edge.
  task automatic advance();
    @(posedge hclk);
    if (!hresetN) begin
      kind      = 0;
      err_phase = 0;
      cnt       = 0;
    end else begin
      if (exp_ready && exp_resp && cnt < 255) cnt++;
      if (exp_ready) begin
        if (exp_hit) begin
          kind = 1;
        end else if (bus.m_htrans >= 2'd2) begin
          kind      = 2;
          err_phase = 1;
        end else begin
          kind = 0;
        end
      end else if (kind == 2) begin
        err_phase = 2;
      end
    end
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic set_req(input logic [31:0] addr, input logic [1:0] trans, input logic wr);
    bus.m_haddr  = addr;
    bus.m_htrans = trans;
    bus.m_hwrite = wr;
    bus.m_hsize  = 3'd2;
    bus.m_hwdata = $urandom;
  endtask

  initial begin
    logic [31:0] r;
    hresetN         = 1'b0;
    set_req(32'h0, 2'd0, 1'b0);
    bus.s_hrdata    = 32'h0;
    bus.s_hreadyout = 1'b1;
    bus.s_hresp     = 1'b0;

    // Reset for two edges; outputs are unknown before the first one.
    repeat (2) @(posedge hclk);
    #1;
    hresetN = 1'b1;
    sample();
    check("rst_hready", {31'h0, bus.m_hready}, 32'h1);
    check("rst_hresp",  {31'h0, bus.m_hresp},  32'h0);
    check("rst_hrdata", bus.m_hrdata,          32'h0);
    check("rst_errcnt", {24'h0, err_count},    32'h0);
    advance();

    // Mapped read, zero wait.
    set_req(32'h0000_0010, 2'd2, 1'b0);
    bus.s_hrdata = 32'hA5A5_5A5A;
    sample();
    check("rd_hsel", {31'h0, bus.s_hsel}, 32'h1);
    advance();
    set_req(32'h0, 2'd0, 1'b0);
    sample();
    check("rd_data", bus.m_hrdata, 32'hA5A5_5A5A);
    advance();

    // Mapped read with two slave wait states.
    set_req(32'h0000_0010, 2'd2, 1'b0);
    tick();
    set_req(32'h0, 2'd0, 1'b0);
    bus.s_hreadyout = 1'b0;
    sample();
    check("wait1_hready", {31'h0, bus.m_hready}, 32'h0);
    advance();
    sample();
    check("wait2_hready", {31'h0, bus.m_hready}, 32'h0);
    advance();
    bus.s_hreadyout = 1'b1;
    sample();
    check("wait3_hready", {31'h0, bus.m_hready}, 32'h1);
    advance();

    // Unmapped NONSEQ: two-cycle ERROR.
    set_req(32'h0001_0000, 2'd2, 1'b0);
    tick();
    set_req(32'h0, 2'd0, 1'b0);
    sample();
    check("err1_hready", {31'h0, bus.m_hready}, 32'h0);
    check("err1_hresp",  {31'h0, bus.m_hresp},  32'h1);
    advance();
    sample();
    check("err2_hready", {31'h0, bus.m_hready}, 32'h1);
    check("err2_hresp",  {31'h0, bus.m_hresp},  32'h1);
    check("err2_hrdata", bus.m_hrdata,          32'h0);
    advance();
    sample();
    check("err_cnt1", {24'h0, err_count}, 32'h1);
    advance();

    // Back-to-back unmapped: second one captured during ERR2.
    set_req(32'h0001_0000, 2'd2, 1'b0);
    tick();
    tick();
    sample();
    check("b2b_err2", {30'h0, bus.m_hready, bus.m_hresp}, 32'h3);
    advance();
    set_req(32'h0, 2'd0, 1'b0);
    sample();
    check("b2b_err1", {30'h0, bus.m_hready, bus.m_hresp}, 32'h1);
    advance();
    tick();
    sample();
    check("b2b_cnt", {24'h0, err_count}, 32'h3);
    advance();

    // IDLE to an unmapped address: zero-wait OKAY.
    set_req(32'h0002_0000, 2'd0, 1'b0);
    tick();
    sample();
    check("idle_unmap", {30'h0, bus.m_hready, bus.m_hresp}, 32'h2);
    advance();

    // Reset during ERR1 aborts the response.
    set_req(32'h0003_0000, 2'd3, 1'b1);
    tick();
    set_req(32'h0, 2'd0, 1'b0);
    hresetN = 1'b0;
    sample();
    check("rst_in_err1", {30'h0, bus.m_hready, bus.m_hresp}, 32'h1);
    advance();
    hresetN = 1'b1;
    sample();
    check("post_rst", {30'h0, bus.m_hready, bus.m_hresp}, 32'h2);
    check("post_rst_cnt", {24'h0, err_count}, 32'h0);
    advance();

    // Saturation: 260 back-to-back error responses.
    set_req(32'h0004_0000, 2'd2, 1'b0);
    repeat (521) tick();
    set_req(32'h0, 2'd0, 1'b0);
    repeat (3) tick();
    sample();
    check("sat_cnt", {24'h0, err_count}, 32'd255);
    advance();

    // Random traffic; address phase only changes when the bus is ready.
    hresetN = 1'b0;
    tick();
    hresetN = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (exp_ready) begin
        r = $urandom;
        if ($urandom_range(0, 1) == 0) begin
          r[31:16] = 16'h0;
        end else if (r[31:16] == 16'h0) begin
          r[31:16] = 16'h8000;
        end
        bus.m_haddr  = r;
        bus.m_htrans = 2'($urandom_range(0, 3));
        bus.m_hwrite = 1'($urandom_range(0, 1));
        bus.m_hsize  = 3'($urandom_range(0, 7));
        bus.m_hwdata = $urandom;
      end
      bus.s_hrdata    = $urandom;
      bus.s_hreadyout = ($urandom_range(0, 3) != 0);
      bus.s_hresp     = ($urandom_range(0, 7) == 0);
      hresetN         = ($urandom_range(0, 49) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
